// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 single-bit mux.
// Optional hold limit: define PRIORITY_FAIRNESS_EN to force release after MAX_HOLD cycles.
module rr_mux8_arbiter #(
    parameter int MAX_HOLD  = 4,
    parameter int RESET_PTR = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] I,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic [2:0] S,
    output logic       Y
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_mux8_arbiter: MAX_HOLD must be 1..255");
    end
    if (RESET_PTR < 0 || RESET_PTR > 7) begin : g_bad_reset_ptr
        $error("rr_mux8_arbiter: RESET_PTR must be 0..7");
    end

    typedef enum logic {IDLE, OWN} state_t;

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [2:0] s_n;
    logic [7:0] gnt_n;
    logic       valid_n;
    logic [2:0] win;
    logic       found;
    logic       take;

`ifdef PRIORITY_FAIRNESS_EN
    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
    logic [7:0] hcnt, hcnt_n;
`endif

    // First requester at or after ptr, wrapping 7 -> 0.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && req[3'(ptr + 3'(i))]) begin
                win   = 3'(ptr + 3'(i));
                found = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_n = state;
        ptr_n   = ptr;
        s_n     = S;
        gnt_n   = gnt;
        valid_n = gnt_valid;
        take    = 1'b0;
`ifdef PRIORITY_FAIRNESS_EN
        hcnt_n  = hcnt;
`endif
        case (state)
            IDLE: take = |req;
            OWN: begin
                if (!req[S]) begin
                    if (|req) begin
                        take = 1'b1;
                    end else begin
                        state_n = IDLE;
                        s_n     = 3'd0;
                        gnt_n   = 8'd0;
                        valid_n = 1'b0;
                    end
                end else begin
`ifdef PRIORITY_FAIRNESS_EN
                    // At the limit, yield only if someone else is actually waiting.
                    if (hcnt == MAX_HOLD_C) begin
                        if (|(req & ~gnt)) take = 1'b1;
                        else               hcnt_n = 8'd1;
                    end else if (hcnt != 8'hFF) begin
                        hcnt_n = hcnt + 8'd1;
                    end
`endif
                end
            end
            default: state_n = IDLE;
        endcase

        if (take) begin
            state_n = OWN;
            s_n     = win;
            gnt_n   = 8'b1 << win;
            valid_n = 1'b1;
            ptr_n   = win + 3'd1;
`ifdef PRIORITY_FAIRNESS_EN
            hcnt_n  = 8'd1;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'(RESET_PTR);
            S         <= 3'd0;
            gnt       <= 8'd0;
            gnt_valid <= 1'b0;
`ifdef PRIORITY_FAIRNESS_EN
            hcnt      <= 8'd0;
`endif
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            S         <= s_n;
            gnt       <= gnt_n;
            gnt_valid <= valid_n;
`ifdef PRIORITY_FAIRNESS_EN
            hcnt      <= hcnt_n;
`endif
        end
    end

    assign Y = gnt_valid & I[S];

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Self-checking bench for rr_mux8_arbiter: directed scenarios plus randomized
// traffic, all checked every cycle against a behavioural ownership model.
module tb_rr_mux8_arbiter;

    localparam int MAX_HOLD  = 4;
    localparam int RESET_PTR = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'd0;
    logic [7:0] I = 8'd0;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] S;
    logic       Y;

    int n_cmp  = 0;
    int n_fail = 0;

    rr_mux8_arbiter #(.MAX_HOLD(MAX_HOLD), .RESET_PTR(RESET_PTR)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .I(I),
        .gnt(gnt), .gnt_valid(gnt_valid), .S(S), .Y(Y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: owner index or -1 when idle ----------------
    int m_owner = -1;
    int m_ptr   = RESET_PTR;
    int m_hcnt  = 0;

    function automatic int search(input int p, input logic [7:0] r);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    function automatic void award(input logic [7:0] r);
        int w;
        w = search(m_ptr, r);
        m_owner = w;
        m_ptr   = (w + 1) % 8;
        m_hcnt  = 1;
    endfunction

    task automatic model_edge(input logic [7:0] r);
        if (m_owner < 0) begin
            if (r != 0) award(r);
        end else if (!r[m_owner]) begin
            if (r != 0) award(r);
            else        m_owner = -1;
        end else begin
`ifdef PRIORITY_FAIRNESS_EN
            if (m_hcnt == MAX_HOLD) begin
                if ((r & ~(8'b1 << m_owner)) != 0) award(r);
                else m_hcnt = 1;
            end else if (m_hcnt < 255) begin
                m_hcnt++;
            end
`endif
        end
    endtask

    // One compare process: outputs checked 1 time unit after every rising edge.
    always @(posedge clk) begin
        logic [7:0] r_edge;
        r_edge = req;
        #1;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = RESET_PTR;
            m_hcnt  = 0;
        end else begin
            model_edge(r_edge);
        end
        check("model_gnt",   gnt,       (m_owner < 0) ? 0 : (32'd1 << m_owner));
        check("model_valid", gnt_valid, (m_owner < 0) ? 0 : 1);
        check("model_S",     S,         (m_owner < 0) ? 0 : m_owner);
        check("model_Y",     Y,         (m_owner < 0) ? 0 : I[m_owner]);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [7:0] r, input logic [7:0] d);
        @(negedge clk);
        req = r;
        I   = d;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] exp_g;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1. asynchronous reset mid-cycle while busy
        repeat (3) step(8'hFF, 8'hFF);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt",   gnt, 0);
        check("rst_valid", gnt_valid, 0);
        check("rst_S",     S, 0);
        check("rst_Y",     Y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2 check("rst_first_grant", gnt, 8'h01);

        // 2. single request, live data path, release to idle
        step(8'h00, 8'h00);
        step(8'h04, 8'h04);
        check("single_gnt", gnt, 8'h04);
        check("single_S",   S, 3'd2);
        check("single_Y1",  Y, 1);
        I = 8'h00;
        #1 check("single_Y0", Y, 0);
        step(8'h00, 8'h00);
        check("single_idle_gnt",   gnt, 0);
        check("single_idle_valid", gnt_valid, 0);

        // 3. rotation with no idle gap
        do_reset();
        step(8'hFF, 8'hA5);
        check("rot_first", gnt, 8'h01);
        for (int k = 0; k < 8; k++) begin
            step(8'hFF & ~(8'b1 << k), 8'hA5);
            exp_g = 8'b1 << ((k + 1) % 8);
            check("rot_gnt",   gnt, exp_g);
            check("rot_S",     S, (k + 1) % 8);
            check("rot_valid", gnt_valid, 1);
            step(8'hFF, 8'hA5);
        end

        // 4. wrap-around 7 -> 0, then idle
        step(8'h80, 8'h01);
        check("wrap_own7", gnt, 8'h80);
        step(8'h81, 8'h01);
        step(8'h01, 8'h01);
        check("wrap_gnt", gnt, 8'h01);
        check("wrap_S",   S, 0);
        check("wrap_Y",   Y, 1);
        step(8'h00, 8'h01);
        check("wrap_idle", gnt_valid, 0);

        // 5. hold limit behaviour
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(8'h03, 8'h00);
`ifdef PRIORITY_FAIRNESS_EN
            exp_g = ((c / MAX_HOLD) % 2 == 1) ? 8'h02 : 8'h01;
`else
            exp_g = 8'h01;
`endif
            check("hold_gnt", gnt, exp_g);
        end
        for (int c = 0; c < 10; c++) begin
            step(8'h01, 8'h00);
            check("hold_solo", gnt, 8'h01);
        end

        // 6. release coinciding with new requests
        do_reset();
        step(8'h04, 8'h00);
        step(8'h22, 8'h00);
        check("simul_gnt", gnt, 8'h20);
        step(8'h02, 8'h00);
        check("simul_next", gnt, 8'h02);

        // randomized traffic: sticky requests so long ownerships occur
        do_reset();
        r = 8'h00;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            if ($urandom_range(0, 39) == 0) r = 8'h00;
            step(r, 8'($urandom));
            if (c == 300) do_reset();
        end

        step(8'h00, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
